pe_mx: RTL and testbench
========================

PE_MX -- requirements
Module: pe_mx

Interface
REQ-001 Parameter ACC_W, default 24: accumulator/result width, signed two's complement, legal range 16..32.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of the fixed-point accumulator in float modes, legal range 0..12.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 a_in  in  8  operand A, westward input.
REQ-006 b_in  in  8  operand B, northward input.
REQ-007 in_vld  in  1  a_in/b_in/clear/fmt form a valid beat.
REQ-008 clear  in  1  with this beat, restart the accumulation.
REQ-009 fmt  in  2  operand format: 00 E4M3, 01 E5M2, 10 INT8 signed, 11 reserved (treated as INT8).
REQ-010 a_out  out  8  a_in delayed by 1 cycle.
REQ-011 b_out  out  8  b_in delayed by 1 cycle.
REQ-012 out_vld  out  1  in_vld delayed by 1 cycle.
REQ-013 drain  in  1  capture the accumulator into the drain register.
REQ-014 shift_en  in  1  drain chain shift: c_out <= c_in.
REQ-015 c_in  in  ACC_W  drain chain input from neighbour PE.
REQ-016 c_out  out  ACC_W  drain register, signed fixed point.
REQ-017 c_vld  out  1  one-cycle pulse after a drain capture.
REQ-018 ovf  out  1  sticky accumulator saturation flag.

Function
REQ-019 a_out, b_out and out_vld SHALL register a_in, b_in and in_vld every cycle, independent of fmt.
REQ-020 E4M3 decode SHALL use e=[6:3], m=[2:0], bias 7: for e=0, value = m*2^-9; otherwise value = (8+m)*2^(e-10).
REQ-021 E5M2 decode SHALL use e=[6:2], m=[1:0], bias 15: for e=0, value = m*2^-16; otherwise value = (4+m)*2^(e-17).
REQ-022 Float modes SHALL have no Inf/NaN codes; every code is finite, and sign = bit 7.
REQ-023 In float modes the product magnitude SHALL be scaled by 2^FRAC_BITS and truncated toward zero.
REQ-024 In float modes the product magnitude SHALL be clamped to 2^(ACC_W-1)-1, and the sign is then applied.
REQ-025 INT8 mode SHALL form the exact signed a*b as a 16-bit integer, sign-extended to ACC_W, with no FRAC_BITS scaling.
REQ-026 Stage 1: on an in_vld edge, the signed product, clear and a valid bit SHALL be registered; fmt is sampled per beat.
REQ-027 Stage 2: when the stage-1 valid bit is set, the accumulator SHALL update on the next edge.
REQ-028 The beat-to-accumulator latency SHALL be 2 cycles.
REQ-029 Stage-2 update SHALL be: if staged clear, acc <= product and ovf <= 0; else acc <= sat(acc + product).
REQ-030 sat() SHALL compute the sum in ACC_W+1 bits and clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-031 Any clamp in sat() SHALL set ovf, and ovf SHALL hold until a staged clear or rst.
REQ-032 A product clamp under REQ-024 SHALL also set ovf.
REQ-033 When in_vld=0, stage 1 SHALL record a bubble; a bubble SHALL leave acc and ovf unchanged.
REQ-034 A clear beat with in_vld=0 SHALL be ignored.
REQ-035 When drain=1, c_out SHALL be loaded with the post-update accumulator value of the same edge.
REQ-036 c_vld SHALL be 1 in the cycle after a drain edge and 0 otherwise.
REQ-037 When shift_en=1 and drain=0, c_out <= c_in and c_vld SHALL stay 0.
REQ-038 drain SHALL take priority over shift_en.
REQ-039 With neither drain nor shift_en asserted, c_out SHALL hold.
REQ-040 drain SHALL NOT modify acc; accumulation continues undisturbed.

Reset
REQ-041 On rst, the following SHALL all be 0 after the edge: a_out, b_out, out_vld, both pipeline stages, acc, c_out, c_vld, ovf.
REQ-042 rst SHALL override every other input, and beats in flight SHALL be discarded.
REQ-043 Beats presented in the cycle after rst deasserts SHALL be processed normally.

Verification
REQ-044 E4M3: ACC_W=24, FRAC_BITS=8; beat a=0x38 (1.0), b=0x40 (2.0), clear=1 -> acc=512 two cycles later; the same beat again without clear -> 1024.
REQ-045 E5M2 plus bubbles: a=0x3C (1.0), b=0xBC (-1.0) on an acc of 512, with an in_vld=0 cycle inserted -> acc=256, out_vld mirrors in_vld.
REQ-046 INT8 saturation: ACC_W=16; three beats of 127*127, the first with clear -> acc 16129, 32258, then 32767 with ovf=1; a next clear beat of 1*1 -> acc=1, ovf=0.
REQ-047 E4M3 denormal: a=0x01, b=0x38 -> product 2^-9*256=0.5 truncated to 0, so acc is unchanged; INT8 a=0x80, b=0x80 -> +16384.
REQ-048 Drain chain: with acc=512, pulse drain -> c_out=512 and c_vld=1 for one cycle; then shift_en with c_in=7 -> c_out=7, c_vld=0; drain and shift_en together -> drain wins.
REQ-049 Reset mid-beat: assert rst one cycle after a valid beat -> all outputs are 0 and the beat is not accumulated; a clear beat after reset accumulates normally.

Source files
------------

// File: rtl/pe_mx.sv
// pe_mx: mixed-format multiply-accumulate processing element for a systolic
// array. Operands flow west/north with one cycle of delay; each valid beat is
// multiplied in E4M3, E5M2 or INT8, then accumulated with saturation. A drain
// register captures the accumulator and forms a shift chain to neighbour PEs.
module pe_mx #(
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              a_in,
  input  logic [7:0]              b_in,
  input  logic                    in_vld,
  input  logic                    clear,
  input  logic [1:0]              fmt,
  output logic [7:0]              a_out,
  output logic [7:0]              b_out,
  output logic                    out_vld,
  input  logic                    drain,
  input  logic                    shift_en,
  input  logic signed [ACC_W-1:0] c_in,
  output logic signed [ACC_W-1:0] c_out,
  output logic                    c_vld,
  output logic                    ovf
);

  localparam logic [1:0]  FMT_E4M3 = 2'b00;
  localparam logic [1:0]  FMT_E5M2 = 2'b01;
  localparam logic [63:0] MAX_POS  = (64'd1 << (ACC_W - 1)) - 64'd1;

  // Unpacked float operand: integer significand and power-of-two exponent.
  typedef struct packed {
    logic [3:0]        man;
    logic signed [6:0] exp;
  } fdec_t;

  // Signed value plus a flag saying it was clamped.
  typedef struct packed {
    logic signed [ACC_W-1:0] val;
    logic                    clamp;
  } res_t;

  // Decode an E4M3 (e5=0) or E5M2 (e5=1) code into man * 2^exp; sign handled by caller.
  function automatic fdec_t decode_fp(input logic [7:0] code, input logic e5);
    fdec_t r;
    if (!e5) begin
      r.man = (code[6:3] == 4'd0) ? {1'b0, code[2:0]} : {1'b1, code[2:0]};
      r.exp = (code[6:3] == 4'd0) ? -7'sd9 : ($signed({3'b000, code[6:3]}) - 7'sd10);
    end else begin
      r.man = (code[6:2] == 5'd0) ? {2'b00, code[1:0]} : {2'b01, code[1:0]};
      r.exp = (code[6:2] == 5'd0) ? -7'sd16 : ($signed({2'b00, code[6:2]}) - 7'sd17);
    end
    return r;
  endfunction

  // Float product scaled by 2^FRAC_BITS, truncated toward zero, magnitude-clamped.
  function automatic res_t fp_mul(input logic [7:0] a, input logic [7:0] b, input logic e5);
    fdec_t             da;
    fdec_t             db;
    logic [7:0]        pm;
    logic signed [8:0] sh;
    logic signed [8:0] nsh;
    logic [63:0]       mag;
    logic [ACC_W-1:0]  m;
    res_t              r;
    da  = decode_fp(a, e5);
    db  = decode_fp(b, e5);
    pm  = {4'd0, da.man} * {4'd0, db.man};
    sh  = 9'(da.exp) + 9'(db.exp) + 9'(FRAC_BITS);
    nsh = -sh;
    if (sh >= 9'sd0) begin
      mag = {56'd0, pm} << sh[5:0];
    end else begin
      mag = (nsh > 9'sd7) ? 64'd0 : ({56'd0, pm} >> nsh[2:0]);
    end
    r.clamp = (mag > MAX_POS);
    if (r.clamp) begin
      mag = MAX_POS;
    end
    m     = mag[ACC_W-1:0];
    r.val = (a[7] ^ b[7]) ? -m : m;
    return r;
  endfunction

  // Exact signed INT8 product, sign-extended to the accumulator width.
  function automatic res_t int_mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ip;
    res_t               r;
    ip      = $signed(a) * $signed(b);
    r.val   = ACC_W'(ip);
    r.clamp = 1'b0;
    return r;
  endfunction

  // Saturating add: sum in ACC_W+1 bits, clamp to the signed ACC_W range.
  function automatic res_t sat_add(input logic signed [ACC_W-1:0] x,
                                   input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W:0] s;
    res_t                  r;
    s       = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    r.clamp = s[ACC_W] ^ s[ACC_W-1];
    if (r.clamp) begin
      r.val = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r.val = s[ACC_W-1:0];
    end
    return r;
  endfunction

  // ---- stage 0: product formation (combinational) ----
  res_t prod_p0;

  // Select the multiplier for this beat's format; reserved code behaves as INT8.
  always_comb begin
    prod_p0 = int_mul(a_in, b_in);
    if (fmt == FMT_E4M3) begin
      prod_p0 = fp_mul(a_in, b_in, 1'b0);
    end else if (fmt == FMT_E5M2) begin
      prod_p0 = fp_mul(a_in, b_in, 1'b1);
    end
  end

  // Systolic pass-through of operands and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out   <= '0;
      b_out   <= '0;
      out_vld <= 1'b0;
    end else begin
      a_out   <= a_in;
      b_out   <= b_in;
      out_vld <= in_vld;
    end
  end

  // ---- stage 1: registered product, clear and valid ----
  logic                    vld_p1;
  logic                    clr_p1;
  logic                    pclamp_p1;
  logic signed [ACC_W-1:0] prod_p1;

  // Capture the beat; an invalid cycle becomes a bubble with no clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      clr_p1    <= 1'b0;
      pclamp_p1 <= 1'b0;
      prod_p1   <= '0;
    end else begin
      vld_p1    <= in_vld;
      clr_p1    <= in_vld & clear;
      pclamp_p1 <= in_vld & prod_p0.clamp;
      prod_p1   <= in_vld ? prod_p0.val : '0;
    end
  end

  // ---- stage 2: accumulator, overflow flag and drain register ----
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic signed [ACC_W-1:0] c_q;
  logic signed [ACC_W-1:0] c_d;
  logic                    c_vld_q;
  logic                    c_vld_d;
  res_t                    sum_p2;

  // Next accumulator: restart on a staged clear, else saturating add; bubbles hold.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    sum_p2 = sat_add(acc_q, prod_p1);
    if (vld_p1) begin
      if (clr_p1) begin
        acc_d = prod_p1;
        ovf_d = pclamp_p1;
      end else begin
        acc_d = sum_p2.val;
        ovf_d = ovf_q | sum_p2.clamp | pclamp_p1;
      end
    end
  end

  // Drain captures the post-update accumulator and wins over shifting.
  always_comb begin
    c_d     = c_q;
    c_vld_d = 1'b0;
    if (drain) begin
      c_d     = acc_d;
      c_vld_d = 1'b1;
    end else if (shift_en) begin
      c_d = c_in;
    end
  end

  // Stage-2 state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      c_q     <= '0;
      c_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      c_q     <= c_d;
      c_vld_q <= c_vld_d;
    end
  end

  assign c_out = c_q;
  assign c_vld = c_vld_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pe_mx.sv
// Directed testbench for pe_mx: a 24-bit instance for float/INT8 checks and a
// 16-bit instance sharing the same stimulus for accumulator saturation.
module tb_pe_mx;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         a_in, b_in;
  logic               in_vld, clear, drain, shift_en;
  logic [1:0]         fmt;
  logic signed [23:0] c_in24;
  logic signed [15:0] c_in16;

  logic [7:0]         a_out, b_out, a_out16, b_out16;
  logic               out_vld, out_vld16;
  logic signed [23:0] c_out;
  logic signed [15:0] c_out16;
  logic               c_vld, c_vld16, ovf, ovf16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_mx #(.ACC_W(24), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_vld(in_vld),
    .clear(clear), .fmt(fmt), .a_out(a_out), .b_out(b_out), .out_vld(out_vld),
    .drain(drain), .shift_en(shift_en), .c_in(c_in24), .c_out(c_out),
    .c_vld(c_vld), .ovf(ovf)
  );

  pe_mx #(.ACC_W(16), .FRAC_BITS(8)) dut16 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_vld(in_vld),
    .clear(clear), .fmt(fmt), .a_out(a_out16), .b_out(b_out16), .out_vld(out_vld16),
    .drain(drain), .shift_en(shift_en), .c_in(c_in16), .c_out(c_out16),
    .c_vld(c_vld16), .ovf(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] f, input logic clr);
    a_in = a; b_in = b; fmt = f; clear = clr; in_vld = 1'b1;
    tick();
    in_vld = 1'b0; clear = 1'b0;
  endtask

  task automatic do_drain();
    drain = 1'b1;
    tick();
    drain = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in = 8'h55; b_in = 8'hAA; fmt = 2'b10; in_vld = 1'b1; clear = 1'b1;
    drain = 1'b1; shift_en = 1'b1; c_in24 = 24'sd5; c_in16 = 16'sd0;
    tick();
    tick();
    n_checks++; if (a_out !== 8'h00) begin n_fail++; $display("FAIL reset_a_out: got %h want 00", a_out); end
    n_checks++; if (b_out !== 8'h00) begin n_fail++; $display("FAIL reset_b_out: got %h want 00", b_out); end
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_checks++; if (c_out !== 24'sd0) begin n_fail++; $display("FAIL reset_c_out: got %0d want 0", c_out); end
    n_checks++; if (c_vld !== 1'b0) begin n_fail++; $display("FAIL reset_c_vld: got %b want 0", c_vld); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_checks++; if (c_out16 !== 16'sd0 || ovf16 !== 1'b0 || out_vld16 !== 1'b0 || a_out16 !== 8'h00 || b_out16 !== 8'h00)
      begin n_fail++; $display("FAIL reset_dut16: c_out=%0d ovf=%b want 0/0", c_out16, ovf16); end
    rst = 1'b0; in_vld = 1'b0; clear = 1'b0; drain = 1'b0; shift_en = 1'b0;
    a_in = 8'h00; b_in = 8'h00; fmt = 2'b00; c_in24 = 24'sd0;
  endtask

  task automatic test_e4m3();
    beat(8'h38, 8'h40, 2'b00, 1'b1);
    n_checks++; if (a_out !== 8'h38 || b_out !== 8'h40) begin n_fail++; $display("FAIL e4m3_passthru: got %h/%h want 38/40", a_out, b_out); end
    n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL e4m3_out_vld: got %b want 1", out_vld); end
    do_drain();
    n_checks++; if (c_out !== 24'sd512) begin n_fail++; $display("FAIL e4m3_first: got %0d want 512", c_out); end
    n_checks++; if (c_vld !== 1'b1) begin n_fail++; $display("FAIL e4m3_c_vld: got %b want 1", c_vld); end
    beat(8'h38, 8'h40, 2'b00, 1'b0);
    do_drain();
    n_checks++; if (c_out !== 24'sd1024) begin n_fail++; $display("FAIL e4m3_accum: got %0d want 1024", c_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL e4m3_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_e5m2_bubble();
    beat(8'h38, 8'h40, 2'b00, 1'b1);
    n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL bubble_vld_hi: got %b want 1", out_vld); end
    tick();
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bubble_vld_lo: got %b want 0", out_vld); end
    beat(8'h3C, 8'hBC, 2'b01, 1'b0);
    do_drain();
    n_checks++; if (c_out !== 24'sd256) begin n_fail++; $display("FAIL e5m2_neg: got %0d want 256", c_out); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_drain();
    n_checks++; if (c_out !== 24'sd256) begin n_fail++; $display("FAIL clear_no_vld: got %0d want 256", c_out); end
  endtask

  task automatic test_denormal_int8();
    beat(8'h38, 8'h40, 2'b00, 1'b1);
    beat(8'h01, 8'h38, 2'b00, 1'b0);
    do_drain();
    n_checks++; if (c_out !== 24'sd512) begin n_fail++; $display("FAIL e4m3_denorm: got %0d want 512", c_out); end
    beat(8'h80, 8'h80, 2'b10, 1'b1);
    do_drain();
    n_checks++; if (c_out !== 24'sd16384) begin n_fail++; $display("FAIL int8_minmin: got %0d want 16384", c_out); end
    beat(8'hFD, 8'h05, 2'b11, 1'b1);
    do_drain();
    n_checks++; if (c_out !== -24'sd15) begin n_fail++; $display("FAIL int8_reserved: got %0d want -15", c_out); end
  endtask

  task automatic test_drain_chain();
    beat(8'h38, 8'h40, 2'b00, 1'b1);
    do_drain();
    n_checks++; if (c_out !== 24'sd512 || c_vld !== 1'b1) begin n_fail++; $display("FAIL drain_cap: got %0d/%b want 512/1", c_out, c_vld); end
    tick();
    n_checks++; if (c_vld !== 1'b0 || c_out !== 24'sd512) begin n_fail++; $display("FAIL drain_pulse: got %0d/%b want 512/0", c_out, c_vld); end
    shift_en = 1'b1; c_in24 = 24'sd7;
    tick();
    shift_en = 1'b0;
    n_checks++; if (c_out !== 24'sd7 || c_vld !== 1'b0) begin n_fail++; $display("FAIL drain_shift: got %0d/%b want 7/0", c_out, c_vld); end
    drain = 1'b1; shift_en = 1'b1; c_in24 = 24'sd99;
    tick();
    drain = 1'b0; shift_en = 1'b0;
    n_checks++; if (c_out !== 24'sd512 || c_vld !== 1'b1) begin n_fail++; $display("FAIL drain_priority: got %0d/%b want 512/1", c_out, c_vld); end
    tick();
    n_checks++; if (c_out !== 24'sd512 || c_vld !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got %0d/%b want 512/0", c_out, c_vld); end
    beat(8'h38, 8'h40, 2'b00, 1'b0);
    do_drain();
    n_checks++; if (c_out !== 24'sd1024) begin n_fail++; $display("FAIL drain_no_disturb: got %0d want 1024", c_out); end
  endtask

  task automatic test_int8_sat();
    beat(8'h7F, 8'h7F, 2'b10, 1'b1);
    do_drain();
    n_checks++; if (c_out16 !== 16'sd16129 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL sat_1: got %0d/%b want 16129/0", c_out16, ovf16); end
    beat(8'h7F, 8'h7F, 2'b10, 1'b0);
    do_drain();
    n_checks++; if (c_out16 !== 16'sd32258 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL sat_2: got %0d/%b want 32258/0", c_out16, ovf16); end
    beat(8'h7F, 8'h7F, 2'b10, 1'b0);
    do_drain();
    n_checks++; if (c_out16 !== 16'sd32767 || ovf16 !== 1'b1) begin n_fail++; $display("FAIL sat_3: got %0d/%b want 32767/1", c_out16, ovf16); end
    beat(8'h01, 8'h01, 2'b10, 1'b1);
    do_drain();
    n_checks++; if (c_out16 !== 16'sd1 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0d/%b want 1/0", c_out16, ovf16); end
  endtask

  task automatic test_product_clamp();
    beat(8'h01, 8'h01, 2'b10, 1'b1);
    beat(8'h7B, 8'hFB, 2'b01, 1'b0);
    do_drain();
    n_checks++; if (c_out !== -24'sd8388606) begin n_fail++; $display("FAIL pclamp_val: got %0d want -8388606", c_out); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL pclamp_ovf: got %b want 1", ovf); end
    tick();
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL pclamp_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    beat(8'h38, 8'h40, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (a_out !== 8'h00 || b_out !== 8'h00 || out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_pass: got %h/%h/%b want 00/00/0", a_out, b_out, out_vld); end
    n_checks++; if (c_out !== 24'sd0 || c_vld !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got %0d/%b/%b want 0/0/0", c_out, c_vld, ovf); end
    beat(8'h38, 8'h40, 2'b00, 1'b0);
    do_drain();
    n_checks++; if (c_out !== 24'sd512) begin n_fail++; $display("FAIL rmid_after: got %0d want 512", c_out); end
    beat(8'h3C, 8'h3C, 2'b01, 1'b1);
    do_drain();
    n_checks++; if (c_out !== 24'sd256 || ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got %0d/%b want 256/0", c_out, ovf); end
  endtask

  initial begin
    test_reset();
    test_e4m3();
    test_e5m2_bubble();
    test_denormal_int8();
    test_drain_chain();
    test_int8_sat();
    test_product_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
